ysyx_210457_axi_bridge: RTL and testbench

//  Responder end of the core's simple memory-request bus: accepts one request
//  (addr/wdata/valid/write/size/id) from the IF/MEM arbiter, runs it as a single-beat
//  AXI4 master transaction, and returns rdata/id with a stall handshake.

---
 rtl/ysyx_210457_axi_bridge.sv | 207 ++++++++++++++++++++
 tb/tb_ysyx_210457_axi_bridge.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_210457_axi_bridge.sv
// Single-beat AXI4 master bridge for the core's memory-request bus (one transaction in flight).
// Optional feature macro: YSYX_210457_BRIDGE_ERR_EN adds a sticky bus_err flag and zeroes failed loads.
module ysyx_210457_axi_bridge #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic [3:0]        req_id,
   output logic [DATA_W-1:0] rsp_data,
   output logic [3:0]        rsp_id,
   output logic              stall,
   output logic [2:0]        dbg_state,
   output logic              aw_valid,
   input  logic              aw_ready,
   output logic [ADDR_W-1:0] aw_addr,
   output logic [3:0]        aw_id,
   output logic [2:0]        aw_size,
   output logic              w_valid,
   input  logic              w_ready,
   output logic [DATA_W-1:0] w_data,
   output logic [7:0]        w_strb,
   output logic              w_last,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic [1:0]        b_resp,
   output logic              ar_valid,
   input  logic              ar_ready,
   output logic [ADDR_W-1:0] ar_addr,
   output logic [3:0]        ar_id,
   output logic [2:0]        ar_size,
   input  logic              r_valid,
   output logic              r_ready,
   input  logic [DATA_W-1:0] r_data,
   input  logic [1:0]        r_resp,
   input  logic              r_last
`ifdef YSYX_210457_BRIDGE_ERR_EN
   ,
   output logic              bus_err
`endif
);

   // Handshakes: a beat transfers on a rising clock edge where valid && ready are both 1;
   // valid never depends combinationally on ready, and once raised stays up until that edge.
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RA   = 3'd1,
      S_RD   = 3'd2,
      S_WA   = 3'd3,
      S_WB   = 3'd4,
      S_DONE = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   rdata_q;
   logic [1:0]          size_q;
   logic [3:0]          id_q;
   logic                write_q;
   logic                aw_done_q;
   logic                w_done_q;
   logic [7:0]          strb_mask;
   logic [DATA_W-1:0]   size_mask;
   logic [DATA_W-1:0]   load_data;
   logic [5:0]          lane_shift;

`ifdef YSYX_210457_BRIDGE_ERR_EN
   logic                err_q;
   logic                bus_err_q;
   logic                unused_in;
   assign unused_in = &{1'b0, r_last};
   assign bus_err   = bus_err_q;
`else
   logic                unused_in;
   assign unused_in = &{1'b0, r_last, r_resp, b_resp};
`endif

   assign dbg_state  = state_q;
   assign lane_shift = {addr_q[2:0], 3'b000};

   always_comb begin
      strb_mask = 8'h01;
      size_mask = DATA_W'(8'hFF);
      case (size_q)
         2'b00: begin strb_mask = 8'h01; size_mask = DATA_W'(8'hFF);         end
         2'b01: begin strb_mask = 8'h03; size_mask = DATA_W'(16'hFFFF);      end
         2'b10: begin strb_mask = 8'h0F; size_mask = DATA_W'(32'hFFFF_FFFF); end
         default: begin strb_mask = 8'hFF; size_mask = '1;                   end
      endcase
   end

   // Lanes shifted past byte 7 fall off the top; accesses are never split.
   assign aw_addr = addr_q;
   assign ar_addr = addr_q;
   assign aw_id   = id_q;
   assign ar_id   = id_q;
   assign aw_size = {1'b0, size_q};
   assign ar_size = {1'b0, size_q};
   assign w_data  = wdata_q << lane_shift;
   assign w_strb  = strb_mask << addr_q[2:0];
   assign w_last  = 1'b1;

`ifdef YSYX_210457_BRIDGE_ERR_EN
   assign load_data = err_q ? '0 : ((rdata_q >> lane_shift) & size_mask);
`else
   assign load_data = (rdata_q >> lane_shift) & size_mask;
`endif

   always_comb begin
      state_d  = state_q;
      stall    = 1'b0;
      ar_valid = 1'b0;
      r_ready  = 1'b0;
      aw_valid = 1'b0;
      w_valid  = 1'b0;
      b_ready  = 1'b0;
      rsp_id   = 4'h0;
      rsp_data = '0;
      case (state_q)
         S_IDLE: begin
            stall = req_valid;
            if (req_valid) state_d = req_write ? S_WA : S_RA;
         end
         S_RA: begin
            stall    = 1'b1;
            ar_valid = 1'b1;
            if (ar_ready) state_d = S_RD;
         end
         S_RD: begin
            stall   = 1'b1;
            r_ready = 1'b1;
            if (r_valid) state_d = S_DONE;
         end
         S_WA: begin
            stall    = 1'b1;
            aw_valid = !aw_done_q;
            w_valid  = !w_done_q;
            if ((aw_done_q || aw_ready) && (w_done_q || w_ready)) state_d = S_WB;
         end
         S_WB: begin
            stall   = 1'b1;
            b_ready = 1'b1;
            if (b_valid) state_d = S_DONE;
         end
         S_DONE: begin
            rsp_id   = id_q;
            rsp_data = write_q ? '0 : load_data;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         size_q    <= 2'b00;
         id_q      <= 4'h0;
         write_q   <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
`ifdef YSYX_210457_BRIDGE_ERR_EN
         err_q     <= 1'b0;
         bus_err_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         if (state_q == S_IDLE && req_valid) begin
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            size_q    <= req_size;
            id_q      <= req_id;
            write_q   <= req_write;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
`ifdef YSYX_210457_BRIDGE_ERR_EN
            err_q     <= 1'b0;
`endif
         end
         if (state_q == S_WA) begin
            if (aw_ready) aw_done_q <= 1'b1;
            if (w_ready)  w_done_q  <= 1'b1;
         end
         if (state_q == S_RD && r_valid) begin
            rdata_q <= r_data;
`ifdef YSYX_210457_BRIDGE_ERR_EN
            err_q <= (r_resp != 2'b00);
            if (r_resp != 2'b00) bus_err_q <= 1'b1;
`endif
         end
`ifdef YSYX_210457_BRIDGE_ERR_EN
         // The flag goes up on the edge into DONE so it is already visible during DONE.
         if (state_q == S_WB && b_valid && b_resp != 2'b00) bus_err_q <= 1'b1;
`endif
      end
   end

endmodule

// File: tb/tb_ysyx_210457_axi_bridge.sv
// Directed bench for ysyx_210457_axi_bridge: bench-driven AXI responder plus response scoreboard.
module tb_ysyx_210457_axi_bridge;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_RA   = 3'd1;
   localparam logic [2:0] ST_RD   = 3'd2;
   localparam logic [2:0] ST_WA   = 3'd3;
   localparam logic [2:0] ST_WB   = 3'd4;
   localparam logic [2:0] ST_DONE = 3'd5;

   logic        clock, reset;
   logic [63:0] req_addr, req_wdata, rsp_data;
   logic        req_valid, req_write, stall;
   logic [1:0]  req_size;
   logic [3:0]  req_id, rsp_id;
   logic [2:0]  dbg_state;
   logic        aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
   logic [63:0] aw_addr, ar_addr, w_data, r_data;
   logic [3:0]  aw_id, ar_id;
   logic [2:0]  aw_size, ar_size;
   logic [7:0]  w_strb;
   logic [1:0]  b_resp, r_resp;
   logic        ar_valid, ar_ready, r_valid, r_ready, r_last;
`ifdef YSYX_210457_BRIDGE_ERR_EN
   logic        bus_err;
`endif

   int          total = 0;
   int          bad = 0;
   int          done_cnt = 0;
   int          exp_done = 0;
   logic [67:0] exp_q[$];
   logic [67:0] mon_e;

   ysyx_210457_axi_bridge dut (
      .clock(clock), .reset(reset),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_valid(req_valid),
      .req_write(req_write), .req_size(req_size), .req_id(req_id),
      .rsp_data(rsp_data), .rsp_id(rsp_id), .stall(stall), .dbg_state(dbg_state),
      .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_id(aw_id), .aw_size(aw_size),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
      .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
      .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id), .ar_size(ar_size),
      .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp), .r_last(r_last)
`ifdef YSYX_210457_BRIDGE_ERR_EN
      , .bus_err(bus_err)
`endif
   );

   // clock / reset
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // reference model of lane placement
   function automatic int nbytes(input logic [1:0] sz);
      return 1 << sz;
   endfunction

   function automatic logic [63:0] exp_load(input logic [63:0] rd, input logic [2:0] off, input logic [1:0] sz);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < 8; i++)
         if (i < nbytes(sz) && int'(off) + i < 8) r[8*i +: 8] = rd[8*(int'(off)+i) +: 8];
      return r;
   endfunction

   function automatic logic [7:0] exp_strb(input logic [2:0] off, input logic [1:0] sz);
      logic [7:0] s;
      s = '0;
      for (int i = 0; i < 8; i++)
         if (i < nbytes(sz) && int'(off) + i < 8) s[int'(off)+i] = 1'b1;
      return s;
   endfunction

   function automatic logic [63:0] exp_wdata(input logic [63:0] wd, input logic [2:0] off, input logic [1:0] sz);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < 8; i++)
         if (i < nbytes(sz) && int'(off) + i < 8) r[8*(int'(off)+i) +: 8] = wd[8*i +: 8];
      return r;
   endfunction

   function automatic logic [63:0] lane_mask(input logic [7:0] s);
      logic [63:0] m;
      for (int j = 0; j < 8; j++) m[8*j +: 8] = {8{s[j]}};
      return m;
   endfunction

   // scoreboard monitor: every DONE pops one expected {id, data}
   always @(negedge clock) begin
      if (!reset) begin
         if (rsp_id !== 4'h0) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
               chk("unexpected_rsp", 64'(rsp_id), 64'h0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("rsp_id", 64'(rsp_id), 64'(mon_e[67:64]));
               chk("rsp_data", rsp_data, mon_e[63:0]);
            end
         end else begin
            chk("rsp_data_idle", rsp_data, 64'h0);
         end
      end
   end

   // driver tasks: each returns at the negedge of the DONE cycle
   task automatic do_load(input logic [63:0] addr, input logic [1:0] sz, input logic [3:0] id,
                          input logic [63:0] rd, input logic [1:0] resp, input int ar_wait);
      logic [63:0] ed;
      ed = exp_load(rd, addr[2:0], sz);
`ifdef YSYX_210457_BRIDGE_ERR_EN
      if (resp != 2'b00) ed = '0;
`endif
      req_addr = addr; req_size = sz; req_id = id; req_write = 1'b0;
      req_wdata = {$urandom, $urandom}; req_valid = 1'b1;
      exp_q.push_back({id, ed});
      exp_done++;
      #1 chk("ld_stall_req", 64'(stall), 64'd1);
      tick();
      req_valid = 1'b0;
      for (int c = 0; c <= ar_wait; c++) begin
         chk("ld_state_ra", 64'(dbg_state), 64'(ST_RA));
         chk("ld_ar_valid", 64'(ar_valid), 64'd1);
         chk("ld_ar_addr", ar_addr, addr);
         chk("ld_ar_size", 64'(ar_size), 64'({1'b0, sz}));
         chk("ld_ar_id", 64'(ar_id), 64'(id));
         chk("ld_stall_ra", 64'(stall), 64'd1);
         ar_ready = (c == ar_wait);
         tick();
      end
      ar_ready = 1'b0;
      chk("ld_state_rd", 64'(dbg_state), 64'(ST_RD));
      chk("ld_r_ready", 64'(r_ready), 64'd1);
      chk("ld_ar_valid_off", 64'(ar_valid), 64'd0);
      chk("ld_stall_rd", 64'(stall), 64'd1);
      r_valid = 1'b1; r_data = rd; r_resp = resp;
      tick();
      r_valid = 1'b0; r_data = {$urandom, $urandom}; r_resp = 2'b00;
      chk("ld_state_done", 64'(dbg_state), 64'(ST_DONE));
      chk("ld_stall_done", 64'(stall), 64'd0);
      chk("ld_r_ready_off", 64'(r_ready), 64'd0);
   endtask

   task automatic do_store(input logic [63:0] addr, input logic [1:0] sz, input logic [63:0] wd,
                           input logic [3:0] id, input int aw_wait, input int w_wait, input logic [1:0] resp);
      logic [7:0]  es;
      logic [63:0] ew, lm;
      int          n;
      es = exp_strb(addr[2:0], sz);
      ew = exp_wdata(wd, addr[2:0], sz);
      lm = lane_mask(es);
      req_addr = addr; req_size = sz; req_id = id; req_write = 1'b1;
      req_wdata = wd; req_valid = 1'b1;
      exp_q.push_back({id, 64'h0});
      exp_done++;
      #1 chk("st_stall_req", 64'(stall), 64'd1);
      tick();
      req_valid = 1'b0;
      n = (aw_wait > w_wait) ? aw_wait : w_wait;
      for (int c = 0; c <= n; c++) begin
         chk("st_state_wa", 64'(dbg_state), 64'(ST_WA));
         chk("st_aw_valid", 64'(aw_valid), 64'(c <= aw_wait));
         chk("st_w_valid", 64'(w_valid), 64'(c <= w_wait));
         chk("st_b_ready_wa", 64'(b_ready), 64'd0);
         chk("st_stall_wa", 64'(stall), 64'd1);
         if (c <= aw_wait) begin
            chk("st_aw_addr", aw_addr, addr);
            chk("st_aw_size", 64'(aw_size), 64'({1'b0, sz}));
            chk("st_aw_id", 64'(aw_id), 64'(id));
         end
         if (c <= w_wait) begin
            chk("st_w_strb", 64'(w_strb), 64'(es));
            chk("st_w_data", w_data & lm, ew);
            chk("st_w_last", 64'(w_last), 64'd1);
         end
         aw_ready = (c == aw_wait);
         w_ready  = (c == w_wait);
         tick();
      end
      aw_ready = 1'b0; w_ready = 1'b0;
      chk("st_state_wb", 64'(dbg_state), 64'(ST_WB));
      chk("st_b_ready", 64'(b_ready), 64'd1);
      chk("st_aw_valid_off", 64'(aw_valid), 64'd0);
      chk("st_w_valid_off", 64'(w_valid), 64'd0);
      b_valid = 1'b1; b_resp = resp;
      tick();
      b_valid = 1'b0; b_resp = 2'b00;
      chk("st_state_done", 64'(dbg_state), 64'(ST_DONE));
      chk("st_stall_done", 64'(stall), 64'd0);
      chk("st_b_ready_off", 64'(b_ready), 64'd0);
   endtask

   initial begin
      logic [63:0] ra, rd;
      logic [1:0]  rs;
      logic [3:0]  rid;
      reset = 1'b1;
      req_addr = '0; req_wdata = '0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_id = 4'h0;
      aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_resp = 2'b00;
      ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; r_resp = 2'b00; r_last = 1'b1;
      tick(); tick();
      chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
      chk("rst_stall", 64'(stall), 64'd0);
      chk("rst_valids", 64'({ar_valid, aw_valid, w_valid}), 64'd0);
      chk("rst_readies", 64'({b_ready, r_ready}), 64'd0);
      chk("rst_rsp_id", 64'(rsp_id), 64'd0);
      chk("rst_rsp_data", rsp_data, 64'd0);
`ifdef YSYX_210457_BRIDGE_ERR_EN
      chk("rst_bus_err", 64'(bus_err), 64'd0);
`endif
      reset = 1'b0;
      tick();

      // T1 word load at offset 4
      do_load(64'h8000_0004, 2'b10, 4'h3, 64'h1122_3344_5566_7788, 2'b00, 0);
      tick();
      // T2 byte store at offset 3, aw_ready late
      do_store(64'h8000_0003, 2'b00, 64'h0000_0000_0000_00AB, 4'h1, 3, 0, 2'b00);
      tick();
      // T3 ar backpressure
      do_load(64'h8000_0100, 2'b11, 4'h1, 64'hCAFE_F00D_1234_5678, 2'b00, 5);
      tick();
      // boundaries: lane overflow on store and load
      do_store(64'h8000_0205, 2'b11, 64'h0102_0304_0506_0708, 4'h1, 0, 2, 2'b00);
      tick();
      do_load(64'h8000_0307, 2'b01, 4'h3, 64'h99AA_BBCC_DDEE_FF00, 2'b00, 0);
      tick();

      // T4 store held valid during DONE of a load
      do_load(64'h8000_0402, 2'b01, 4'h3, 64'h0F0E_0D0C_0B0A_0908, 2'b00, 1);
      req_addr = 64'h8000_0500; req_size = 2'b10; req_id = 4'h1; req_write = 1'b1;
      req_wdata = 64'h0000_0000_DEAD_BEEF; req_valid = 1'b1;
      #1 chk("b2b_stall_done", 64'(stall), 64'd0);
      chk("b2b_aw_valid_done", 64'(aw_valid), 64'd0);
      tick();
      chk("b2b_state_idle", 64'(dbg_state), 64'(ST_IDLE));
      chk("b2b_stall_idle", 64'(stall), 64'd1);
      do_store(64'h8000_0500, 2'b10, 64'h0000_0000_DEAD_BEEF, 4'h1, 0, 0, 2'b00);
      tick();

      // T5 reset while waiting for read data
      req_addr = 64'h8000_0010; req_size = 2'b11; req_id = 4'h1; req_write = 1'b0; req_valid = 1'b1;
      tick();
      req_valid = 1'b0; ar_ready = 1'b1;
      chk("t5_state_ra", 64'(dbg_state), 64'(ST_RA));
      tick();
      ar_ready = 1'b0;
      chk("t5_state_rd", 64'(dbg_state), 64'(ST_RD));
      reset = 1'b1;
      #1 chk("t5_state_idle", 64'(dbg_state), 64'(ST_IDLE));
      chk("t5_stall", 64'(stall), 64'd0);
      chk("t5_valids", 64'({ar_valid, aw_valid, w_valid, r_ready, b_ready}), 64'd0);
      r_valid = 1'b1; r_data = 64'h5555_AAAA_5555_AAAA;
      tick();
      r_valid = 1'b0; reset = 1'b0;
      tick();
      chk("t5_after_idle", 64'(dbg_state), 64'(ST_IDLE));
      do_load(64'h8000_0010, 2'b11, 4'h3, 64'h7766_5544_3322_1100, 2'b00, 0);
      tick();

      // response codes: ignored by default, flagged when the error feature is built in
`ifdef YSYX_210457_BRIDGE_ERR_EN
      chk("t6_bus_err_clear", 64'(bus_err), 64'd0);
      do_store(64'h8000_0600, 2'b11, 64'h1111_2222_3333_4444, 4'h1, 1, 1, 2'b10);
      chk("t6_bus_err_done", 64'(bus_err), 64'd1);
      tick();
      do_load(64'h8000_0600, 2'b11, 4'h3, 64'h0123_4567_89AB_CDEF, 2'b00, 0);
      chk("t6_bus_err_sticky", 64'(bus_err), 64'd1);
      tick();
      do_load(64'h8000_0604, 2'b10, 4'h3, 64'h0123_4567_89AB_CDEF, 2'b10, 0);
      tick();
`else
      do_load(64'h8000_0604, 2'b10, 4'h3, 64'h0123_4567_89AB_CDEF, 2'b10, 0);
      tick();
      do_store(64'h8000_0600, 2'b11, 64'h1111_2222_3333_4444, 4'h1, 1, 1, 2'b11);
      tick();
`endif

      // randomized mix
      for (int k = 0; k < 8; k++) begin
         ra  = 64'h8000_0000 + 64'($urandom_range(0, 255));
         rd  = {$urandom, $urandom};
         rs  = 2'($urandom_range(0, 3));
         rid = ($urandom_range(0, 1) == 0) ? 4'h1 : 4'h3;
         if ($urandom_range(0, 1) == 0)
            do_load(ra, rs, rid, rd, 2'b00, $urandom_range(0, 3));
         else
            do_store(ra, rs, rd, rid, $urandom_range(0, 3), $urandom_range(0, 3), 2'b00);
         tick();
      end

      tick(); tick();
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      chk("done_count", 64'(done_cnt), 64'(exp_done));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
